// File: rtl/ibex_prefetch_buffer_nreq.sv
// Instruction prefetch buffer: up to NUM_REQS fetches in flight, an internal
// response FIFO, credit-based issue and discard of stale fetches after a branch.
module ibex_prefetch_buffer_nreq #(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  input  logic                          branch_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [ADDR_W-1:0]             addr_o,
  output logic                          err_o,
  output logic                          instr_req_o,
  input  logic                          instr_gnt_i,
  output logic [ADDR_W-1:0]             instr_addr_o,
  input  logic [DATA_W-1:0]             instr_rdata_i,
  input  logic                          instr_err_i,
  input  logic                          instr_pmp_err_i,
  input  logic                          instr_rvalid_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQS+1)-1:0] outstanding_o
);
  localparam int unsigned OW = $clog2(NUM_REQS + 1);
  localparam int unsigned QW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int unsigned FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  logic [ADDR_W-1:0]     r_fetch_addr;
  logic                  r_held;
  logic                  r_held_disc;
  logic [ADDR_W-1:0]     r_held_addr;
  logic [ADDR_W-1:0]     r_q_addr [NUM_REQS];
  logic [NUM_REQS-1:0]   r_q_pmp;
  logic [NUM_REQS-1:0]   r_q_disc;
  logic [QW-1:0]         r_q_rd;
  logic [QW-1:0]         r_q_wr;
  logic [OW-1:0]         r_out_cnt;
  logic [OW-1:0]         r_disc_cnt;
  logic [DATA_W-1:0]     r_f_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_f_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_f_err;
  logic [FW-1:0]         r_f_rd;
  logic [FW-1:0]         r_f_wr;
  logic [CW-1:0]         r_f_cnt;
  logic [DATA_W-1:0]     r_last_data;
  logic [ADDR_W-1:0]     r_last_addr;
  logic                  r_last_err;

  logic [ADDR_W-1:0] w_branch_addr;
  logic [OW-1:0]     w_live;
  logic              w_credit;
  logic              w_new;
  logic              w_accept;
  logic              w_acc_disc;
  logic              w_head_pmp;
  logic              w_head_disc;
  logic              w_complete;
  logic              w_push;
  logic              w_pop;
  logic              w_f_nempty;
  logic [QW-1:0]     w_q_rd_nxt;
  logic [QW-1:0]     w_q_wr_nxt;
  logic [FW-1:0]     w_f_rd_nxt;
  logic [FW-1:0]     w_f_wr_nxt;

  // Issue: credit counts buffered entries plus live (non-discarded) fetches
  assign w_branch_addr = addr_i & ~ADDR_W'(3);
  assign w_live        = r_out_cnt - r_disc_cnt;
  assign w_credit      = (SW'(r_f_cnt) + SW'(w_live)) < SW'(FIFO_DEPTH);
  assign w_new         = ~rst_i & ~r_held & req_i & (r_out_cnt < OW'(NUM_REQS)) &
                         (branch_i | w_credit);
  assign instr_req_o   = r_held | w_new;
  assign instr_addr_o  = r_held ? r_held_addr : (branch_i ? w_branch_addr : r_fetch_addr);
  assign w_accept      = instr_req_o & (instr_gnt_i | instr_pmp_err_i);
  assign w_acc_disc    = r_held & (r_held_disc | branch_i);

  // PMP-blocked slots retire on their own; no bus response will come for them
  assign w_head_pmp  = r_q_pmp[r_q_rd];
  assign w_head_disc = r_q_disc[r_q_rd];
  assign w_complete  = (r_out_cnt != '0) & (instr_rvalid_i | w_head_pmp);
  assign w_push      = w_complete & ~w_head_disc & ~branch_i;

  assign w_f_nempty = (r_f_cnt != '0);
  assign valid_o    = w_f_nempty & ~branch_i;
  assign w_pop      = valid_o & ready_i;
  assign rdata_o    = w_f_nempty ? r_f_data[r_f_rd] : r_last_data;
  assign addr_o     = w_f_nempty ? r_f_addr[r_f_rd] : r_last_addr;
  assign err_o      = w_f_nempty ? r_f_err[r_f_rd]  : r_last_err;

  assign busy_o        = (r_out_cnt != '0) | instr_req_o;
  assign outstanding_o = r_out_cnt;

  assign w_q_rd_nxt = (r_q_rd == QW'(NUM_REQS - 1))   ? '0 : r_q_rd + QW'(1);
  assign w_q_wr_nxt = (r_q_wr == QW'(NUM_REQS - 1))   ? '0 : r_q_wr + QW'(1);
  assign w_f_rd_nxt = (r_f_rd == FW'(FIFO_DEPTH - 1)) ? '0 : r_f_rd + FW'(1);
  assign w_f_wr_nxt = (r_f_wr == FW'(FIFO_DEPTH - 1)) ? '0 : r_f_wr + FW'(1);

  // Payload storage carries no reset; occupancy is tracked by the control state
  always_ff @(posedge clk_i) begin
    if (w_accept) r_q_addr[r_q_wr] <= instr_addr_o;
    if (w_push) begin
      r_f_data[r_f_wr] <= instr_rdata_i & {DATA_W{~w_head_pmp}};
      r_f_addr[r_f_wr] <= r_q_addr[r_q_rd];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_addr <= '0;
      r_held       <= 1'b0;
      r_held_disc  <= 1'b0;
      r_held_addr  <= '0;
      r_q_pmp      <= '0;
      r_q_disc     <= '0;
      r_q_rd       <= '0;
      r_q_wr       <= '0;
      r_out_cnt    <= '0;
      r_disc_cnt   <= '0;
      r_f_err      <= '0;
      r_f_rd       <= '0;
      r_f_wr       <= '0;
      r_f_cnt      <= '0;
      r_last_data  <= '0;
      r_last_addr  <= '0;
      r_last_err   <= 1'b0;
    end else begin
      // A request stays on the bus, address frozen, until granted or PMP-blocked
      if (w_accept) begin
        r_held      <= 1'b0;
        r_held_disc <= 1'b0;
      end else if (instr_req_o) begin
        r_held      <= 1'b1;
        r_held_addr <= instr_addr_o;
        r_held_disc <= w_acc_disc;
      end
      // A stale held request being accepted must not disturb the redirected stream
      if (w_accept && !w_acc_disc) r_fetch_addr <= instr_addr_o + ADDR_W'(4);
      else if (branch_i)           r_fetch_addr <= w_branch_addr;

      if (branch_i) r_q_disc <= '1;
      if (w_accept) begin
        r_q_pmp[r_q_wr]  <= instr_pmp_err_i;
        r_q_disc[r_q_wr] <= w_acc_disc;
        r_q_wr           <= w_q_wr_nxt;
      end
      if (w_complete) r_q_rd <= w_q_rd_nxt;
      r_out_cnt <= r_out_cnt + OW'(w_accept) - OW'(w_complete);
      if (branch_i)
        r_disc_cnt <= r_out_cnt - OW'(w_complete) + OW'(w_accept & w_acc_disc);
      else
        r_disc_cnt <= r_disc_cnt - OW'(w_complete & w_head_disc) + OW'(w_accept & w_acc_disc);

      if (w_f_nempty) begin
        r_last_data <= r_f_data[r_f_rd];
        r_last_addr <= r_f_addr[r_f_rd];
        r_last_err  <= r_f_err[r_f_rd];
      end
      if (branch_i) begin
        r_f_rd  <= '0;
        r_f_wr  <= '0;
        r_f_cnt <= '0;
      end else begin
        if (w_push) begin
          r_f_err[r_f_wr] <= instr_err_i | w_head_pmp;
          r_f_wr          <= w_f_wr_nxt;
        end
        if (w_pop) r_f_rd <= w_f_rd_nxt;
        r_f_cnt <= r_f_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_ibex_prefetch_buffer_nreq.sv
// Randomized and directed bench for ibex_prefetch_buffer_nreq against a
// queue-based behavioural model of the fetch stream.
module tb_ibex_prefetch_buffer_nreq;
  localparam int unsigned NUM_REQS   = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o, err_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o, instr_rdata_i;
  logic        instr_gnt_i, instr_err_i, instr_pmp_err_i, instr_rvalid_i;
  logic [1:0]  outstanding_o;

  ibex_prefetch_buffer_nreq #(
    .NUM_REQS(NUM_REQS), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .instr_pmp_err_i(instr_pmp_err_i), .instr_rvalid_i(instr_rvalid_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; bit pmp; bit disc; } slot_t;
  typedef struct { logic [31:0] data; logic [31:0] addr; bit err; } ent_t;

  slot_t       m_q[$];
  ent_t        m_f[$];
  ent_t        m_last;
  logic [31:0] m_fetch, m_held_addr;
  bit          m_held, m_held_disc;

  bit          s_req, s_branch, s_ready, s_gnt, s_pmp, s_rv_want, s_raw_rv, s_err;
  logic [31:0] s_addr, s_rdata;
  bit          rv_cur;

  bit          e_req, e_valid, e_busy;
  logic [31:0] e_addr;
  ent_t        e_head;
  int          e_out;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_f.delete();
    m_last = '{data: 32'd0, addr: 32'd0, err: 1'b0};
    m_fetch = 32'd0;
    m_held_addr = 32'd0;
    m_held = 1'b0;
    m_held_disc = 1'b0;
  endtask

  task automatic set_idle();
    s_req = 0; s_branch = 0; s_ready = 0; s_gnt = 0; s_pmp = 0;
    s_rv_want = 0; s_raw_rv = 0; s_err = 0; s_addr = 32'd0; s_rdata = 32'd0;
  endtask

  // Expected combinational outputs for the current state and stimulus
  task automatic predict();
    int  live;
    bit  new_ok;
    live = 0;
    foreach (m_q[i]) if (!m_q[i].disc) live++;
    new_ok = !m_held && s_req && (m_q.size() < int'(NUM_REQS)) &&
             (s_branch || (m_f.size() + live < int'(FIFO_DEPTH)));
    e_req   = m_held || new_ok;
    e_addr  = m_held ? m_held_addr : (s_branch ? (s_addr & ~32'd3) : m_fetch);
    e_valid = (m_f.size() > 0) && !s_branch;
    e_head  = (m_f.size() > 0) ? m_f[0] : m_last;
    e_out   = m_q.size();
    e_busy  = (m_q.size() > 0) || e_req;
  endtask

  task automatic drive();
    @(negedge clk_i);
    rv_cur = s_raw_rv;
    if (s_rv_want && m_q.size() > 0) begin
      if (!m_q[0].pmp) rv_cur = 1'b1;
    end
    if (rv_cur && m_q.size() == 0)
      assert (s_raw_rv) else $error("response without outstanding fetch");
    req_i = s_req; branch_i = s_branch; addr_i = s_addr; ready_i = s_ready;
    instr_gnt_i = s_gnt; instr_pmp_err_i = s_pmp; instr_rvalid_i = rv_cur;
    instr_rdata_i = s_rdata; instr_err_i = s_err;
    predict();
    #1;
    chk("instr_req", 64'(instr_req_o), 64'(e_req));
    chk("instr_addr", 64'(instr_addr_o), 64'(e_addr));
    chk("valid", 64'(valid_o), 64'(e_valid));
    chk("rdata", 64'(rdata_o), 64'(e_head.data));
    chk("addr", 64'(addr_o), 64'(e_head.addr));
    chk("err", 64'(err_o), 64'(e_head.err));
    chk("outstanding", 64'(outstanding_o), 64'(e_out));
    chk("busy", 64'(busy_o), 64'(e_busy));
  endtask

  // Model state update for the edge that ends the current cycle
  task automatic advance();
    bit    acc, acc_disc, cmp;
    slot_t s;
    ent_t  e;
    acc      = e_req && (s_gnt || s_pmp);
    acc_disc = m_held && (m_held_disc || s_branch);
    if (m_f.size() > 0) m_last = m_f[0];
    if (e_valid && s_ready) void'(m_f.pop_front());
    cmp = 1'b0;
    if (m_q.size() > 0) cmp = rv_cur || m_q[0].pmp;
    if (cmp) begin
      s = m_q.pop_front();
      if (!s.disc && !s_branch) begin
        e.data = s.pmp ? 32'd0 : s_rdata;
        e.addr = s.addr;
        e.err  = s.pmp || s_err;
        m_f.push_back(e);
      end
    end
    if (s_branch) begin
      m_f.delete();
      foreach (m_q[i]) m_q[i].disc = 1'b1;
    end
    assert (m_f.size() <= int'(FIFO_DEPTH)) else $error("response buffer overflow");
    if (acc) begin
      s.addr = e_addr; s.pmp = s_pmp; s.disc = acc_disc;
      m_q.push_back(s);
      if (!acc_disc) m_fetch = e_addr + 32'd4;
      else if (s_branch) m_fetch = s_addr & ~32'd3;
      m_held = 1'b0;
      m_held_disc = 1'b0;
    end else begin
      if (s_branch) m_fetch = s_addr & ~32'd3;
      if (e_req) begin
        m_held = 1'b1;
        m_held_addr = e_addr;
        m_held_disc = acc_disc;
      end
    end
    @(posedge clk_i);
  endtask

  task automatic tick();
    drive();
    advance();
  endtask

  // Reset is asserted with req_i left as it was, so the outputs must be gated
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    branch_i = 0; instr_gnt_i = 0; instr_pmp_err_i = 0; instr_rvalid_i = 0; ready_i = 0;
    m_reset();
    #1;
    chk("rst_async_req", 64'(instr_req_o), 64'd0);
    chk("rst_async_out", 64'(outstanding_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_req", 64'(instr_req_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_out", 64'(outstanding_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_iaddr", 64'(instr_addr_o), 64'd0);
    @(negedge clk_i);
    req_i = 0;
    rst_i = 1'b0;
    set_idle();
  endtask

  initial begin
    int          n;
    bit          got;
    logic [31:0] first_req, first_valid, pmp_next_data;
    rst_i = 1'b1; req_i = 0; branch_i = 0; addr_i = 0; ready_i = 0; instr_gnt_i = 0;
    instr_rdata_i = 0; instr_err_i = 0; instr_pmp_err_i = 0; instr_rvalid_i = 0;
    set_idle();
    m_reset();
    repeat (2) @(posedge clk_i);
    do_reset();

    // Branch to 0x100 with immediate grants until both slots are in flight
    s_req = 1; s_branch = 1; s_addr = 32'h100; s_gnt = 1;
    drive(); chk("t1_addr0", 64'(instr_addr_o), 64'h100); advance();
    s_branch = 0;
    drive(); chk("t1_addr1", 64'(instr_addr_o), 64'h104); advance();
    s_req = 0; s_rv_want = 1;
    drive(); chk("t1_req_stop", 64'(instr_req_o), 64'd0);
    chk("t1_out2", 64'(outstanding_o), 64'd2); advance();
    s_ready = 1;
    drive(); chk("t1_v0", 64'(valid_o), 64'd1); chk("t1_a0", 64'(addr_o), 64'h100); advance();
    s_rv_want = 0;
    drive(); chk("t1_a1", 64'(addr_o), 64'h104); advance();
    tick();

    // Stalled consumer: buffer fills to FIFO_DEPTH and issue stops
    s_req = 1; s_gnt = 1; s_rv_want = 1; s_ready = 0;
    repeat (12) tick();
    drive(); chk("t2_req_drop", 64'(instr_req_o), 64'd0); advance();
    s_ready = 1;
    tick();
    s_ready = 0;
    n = 0;
    repeat (8) begin
      drive();
      if (instr_req_o && instr_gnt_i) n++;
      advance();
    end
    chk("t2_one_req", 64'(n), 64'd1);
    s_req = 0; s_ready = 1;
    n = 0;
    repeat (10) begin
      drive();
      if (valid_o) n++;
      advance();
    end
    chk("t2_buffered", 64'(n), 64'd4);

    // Branch while one fetch is in flight and 0x108 is held ungranted
    do_reset();
    s_req = 1; s_branch = 1; s_addr = 32'h100; s_gnt = 1;
    tick();
    s_branch = 0;
    tick();
    s_gnt = 0; s_rv_want = 1;
    tick();
    s_rv_want = 0;
    drive(); chk("t3_held_issue", 64'(instr_addr_o), 64'h108); advance();
    s_branch = 1; s_addr = 32'h200;
    drive(); chk("t3_hold_br", 64'(instr_addr_o), 64'h108);
    chk("t3_valid_forced", 64'(valid_o), 64'd0); advance();
    s_branch = 0;
    drive(); chk("t3_hold", 64'(instr_addr_o), 64'h108); advance();
    s_gnt = 1;
    tick();
    s_rv_want = 1;
    got = 0; first_req = 32'hdead_beef; first_valid = 32'hdead_beef;
    for (int i = 0; i < 10; i++) begin
      drive();
      if (instr_req_o && instr_gnt_i && !got) begin
        first_req = instr_addr_o;
        got = 1;
      end
      if (valid_o && first_valid == 32'hdead_beef) first_valid = addr_o;
      advance();
    end
    chk("t3_next_req", 64'(first_req), 64'h200);
    chk("t3_first_valid", 64'(first_valid), 64'h200);

    // PMP-blocked fetch at 0x300 followed by a normal fetch
    do_reset();
    s_req = 1; s_branch = 1; s_addr = 32'h300; s_pmp = 1;
    drive(); chk("t4_addr", 64'(instr_addr_o), 64'h300); advance();
    s_branch = 0; s_pmp = 0; s_gnt = 1;
    drive(); chk("t4_addr_next", 64'(instr_addr_o), 64'h304);
    chk("t4_not_yet", 64'(valid_o), 64'd0); advance();
    s_req = 0; s_gnt = 0; s_rv_want = 1; s_ready = 1;
    pmp_next_data = $urandom();
    s_rdata = pmp_next_data;
    drive(); chk("t4_valid", 64'(valid_o), 64'd1); chk("t4_err", 64'(err_o), 64'd1);
    chk("t4_rdata", 64'(rdata_o), 64'd0); chk("t4_a", 64'(addr_o), 64'h300); advance();
    s_rv_want = 0;
    drive(); chk("t4_a2", 64'(addr_o), 64'h304); chk("t4_err2", 64'(err_o), 64'd0);
    chk("t4_rdata2", 64'(rdata_o), 64'(pmp_next_data)); advance();

    // Address wrap at the top of the address space
    do_reset();
    s_req = 1; s_branch = 1; s_addr = 32'hFFFF_FFFE; s_gnt = 1;
    drive(); chk("t5_top", 64'(instr_addr_o), 64'hFFFF_FFFC); advance();
    s_branch = 0;
    drive(); chk("t5_wrap", 64'(instr_addr_o), 64'h0); advance();
    s_req = 0; s_gnt = 0; s_rv_want = 1; s_ready = 1;
    repeat (4) tick();

    // Reset while fetches are in flight and the buffer holds entries
    do_reset();
    s_req = 1; s_branch = 1; s_addr = 32'h400; s_gnt = 1;
    tick();
    s_branch = 0; s_rv_want = 1;
    for (int i = 0; i < 20; i++) begin
      if (m_f.size() == 3 && m_q.size() >= 1) break;
      tick();
    end
    do_reset();
    s_raw_rv = 1; s_rdata = 32'h1234_5678;
    repeat (3) begin
      drive();
      chk("t6_stale_valid", 64'(valid_o), 64'd0);
      chk("t6_stale_out", 64'(outstanding_o), 64'd0);
      advance();
    end
    set_idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      s_req     = ($urandom_range(0, 9) != 0);
      s_branch  = ($urandom_range(0, 15) == 0);
      s_addr    = $urandom();
      s_ready   = ($urandom_range(0, 1) == 1);
      s_gnt     = ($urandom_range(0, 9) < 6);
      s_pmp     = ($urandom_range(0, 31) == 0);
      s_rv_want = ($urandom_range(0, 9) < 6);
      s_rdata   = $urandom();
      s_err     = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
